pe_psum_collector: RTL and testbench

Downstream stage of the PE unit. Consumes the 14-bit partial sums on the PE chain's `Psum_out` and accumulates ROWS consecutive partial sums into one output pixel. Each completed sum is post-processed with ReLU, an arithmetic right shift and saturation to 8 bits. Results are buffered in a small FIFO and delivered over a valid/ready handshake to the output-feature-map writer.

---
 rtl/pe_psum_collector.sv | 86 ++++++++
 tb/tb_pe_psum_collector.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/pe_psum_collector.sv
// pe_psum_collector: groups ROWS partial sums into one pixel, applies ReLU/shift/saturate,
// and buffers the results in a small FIFO with a valid/ready output.
module pe_psum_collector #(
   parameter int PSUM_W = 14,
   parameter int ACC_W  = 18,
   parameter int ROWS   = 3,
   parameter int SHIFT  = 4,
   parameter int OUT_W  = 8,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              clear,
   input  logic              psum_valid,
   input  logic [PSUM_W-1:0] Psum_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [OUT_W-1:0]  out_data,
   output logic              out_sat,
   output logic              fifo_full,
   output logic              ovf
);
   localparam int CW = ROWS > 1 ? $clog2(ROWS) : 1;
   localparam int AW = $clog2(DEPTH);
   localparam logic [ACC_W-1:0] MAXV = ACC_W'((1 << OUT_W) - 1);

   logic [CW-1:0]           r_cnt;
   logic signed [ACC_W-1:0] r_acc;
   logic [AW:0]             r_occ;
   logic [AW-1:0]           r_wr, r_rd;
   logic [OUT_W:0]          r_mem [DEPTH];

   logic signed [ACC_W-1:0] w_sext, w_sum, w_q;
   logic                    w_accept, w_last, w_done, w_full, w_pop, w_push, w_drop, w_sat;
   logic [OUT_W-1:0]        w_data;

   assign w_accept = en & psum_valid & ~clear;
   assign w_last   = r_cnt == CW'(ROWS - 1);
   assign w_done   = w_accept & w_last;
   assign w_sext   = {{(ACC_W-PSUM_W){Psum_in[PSUM_W-1]}}, Psum_in};
   assign w_sum    = (r_cnt == '0) ? w_sext : r_acc + w_sext;
   assign w_q      = w_sum >>> SHIFT;
   assign w_sat    = ~w_sum[ACC_W-1] & ($unsigned(w_q) > MAXV);
   assign w_data   = w_sum[ACC_W-1] ? '0 : w_sat ? '1 : w_q[OUT_W-1:0];

   assign w_full    = r_occ == (AW+1)'(DEPTH);
   assign fifo_full = w_full;
   assign out_valid = r_occ != '0;
   assign {out_data, out_sat} = out_valid ? r_mem[r_rd] : '0;
   assign w_pop  = out_valid & out_ready & ~clear;
   // a full FIFO still accepts a pixel when the head leaves in the same cycle
   assign w_push = w_done & (~w_full | w_pop);
   assign w_drop = w_done & w_full & ~w_pop;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
         r_acc <= '0;
         r_occ <= '0;
         r_wr  <= '0;
         r_rd  <= '0;
         ovf   <= 1'b0;
      end else if (clear) begin
         r_cnt <= '0;
         r_acc <= '0;
         r_occ <= '0;
         r_wr  <= '0;
         r_rd  <= '0;
         ovf   <= 1'b0;
      end else begin
         if (w_accept) begin
            r_acc <= w_sum;
            r_cnt <= w_last ? '0 : r_cnt + CW'(1);
         end
         if (w_push) r_wr <= r_wr + AW'(1);
         if (w_pop) r_rd <= r_rd + AW'(1);
         r_occ <= r_occ + (AW+1)'(w_push) - (AW+1)'(w_pop);
         if (w_drop) ovf <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr] <= {w_data, w_sat};
   end
endmodule

// File: tb/tb_pe_psum_collector.sv
// tb_pe_psum_collector: directed steps with an expected-pixel queue checked on every pop.
module tb_pe_psum_collector;
   logic        clk = 1'b0;
   logic        rst_n, en, clear, psum_valid, out_ready;
   logic [13:0] Psum_in;
   logic        out_valid, out_sat, fifo_full, ovf;
   logic [7:0]  out_data;
   logic [8:0]  exp_q[$];
   int          checks = 0;
   int          errors = 0;

   pe_psum_collector dut (
      .clk(clk), .rst_n(rst_n), .en(en), .clear(clear), .psum_valid(psum_valid),
      .Psum_in(Psum_in), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_sat(out_sat), .fifo_full(fifo_full), .ovf(ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      assert (got === want) else begin
         errors++;
         $error("FAIL %s got %0d expected %0d", tag, got, want);
      end
   endtask

   task automatic drive(input int v);
      psum_valid = 1'b1;
      Psum_in    = 14'(v);
      @(posedge clk);
      #1;
      psum_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL pop_unexpected got %0d/%0d expected none", out_data, out_sat);
         end else begin
            logic [8:0] e;
            e = exp_q.pop_front();
            assert ({out_data, out_sat} === e) else begin
               errors++;
               $error("FAIL pop_data got %0d/%0d expected %0d/%0d", out_data, out_sat, e[8:1], e[0]);
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0; en = 1'b1; clear = 1'b0; psum_valid = 1'b0; out_ready = 1'b1; Psum_in = '0;
      #12;
      chk("rst_valid", out_valid, 0);
      chk("rst_data", out_data, 0);
      chk("rst_sat", out_sat, 0);
      chk("rst_full", fifo_full, 0);
      chk("rst_ovf", ovf, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(1);
      // basic pixel: 600 >>> 4 = 37
      drive(100); drive(200);
      exp_q.push_back({8'd37, 1'b0});
      drive(300);
      chk("latency_valid", out_valid, 1);
      idle(2);
      // saturation: 24573 >>> 4 = 1535
      drive(8191); drive(8191);
      exp_q.push_back({8'd255, 1'b1});
      drive(8191);
      idle(2);
      // negative sum clamps to zero
      drive(-8192); drive(100);
      exp_q.push_back({8'd0, 1'b0});
      drive(100);
      idle(2);
      chk("drained1", exp_q.size(), 0);
      // fill FIFO with out_ready low, then overflow one pixel
      out_ready = 1'b0;
      for (int i = 0; i < 12; i++) drive(160);
      chk("full_set", fifo_full, 1);
      chk("ovf_not_yet", ovf, 0);
      repeat (3) drive(160);
      chk("ovf_set", ovf, 1);
      chk("held_data", out_data, 30);
      idle(2);
      chk("held_data2", out_data, 30);
      repeat (4) exp_q.push_back({8'd30, 1'b0});
      out_ready = 1'b1;
      idle(4);
      chk("drained_pops", exp_q.size(), 0);
      chk("full_clr", fifo_full, 0);
      chk("empty_after", out_valid, 0);
      chk("ovf_sticky", ovf, 1);
      clear = 1'b1;
      idle(1);
      clear = 1'b0;
      chk("ovf_cleared", ovf, 0);
      // en=0 freezes the group
      drive(16);
      en = 1'b0; psum_valid = 1'b1; Psum_in = 14'd500;
      idle(1);
      en = 1'b1; psum_valid = 1'b0;
      drive(32);
      exp_q.push_back({8'd6, 1'b0});
      drive(48);
      idle(2);
      chk("drained_en", exp_q.size(), 0);
      // reset mid-group discards the partial sum
      drive(160); drive(160);
      rst_n = 1'b0;
      #2;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_data", out_data, 0);
      chk("mid_rst_ovf", ovf, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      drive(160); drive(160);
      exp_q.push_back({8'd30, 1'b0});
      drive(160);
      chk("post_rst_valid", out_valid, 1);
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
      chk("final_drain", exp_q.size(), 0);
      chk("post_rst_ovf", ovf, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
